// File: rtl/adc_boxcar_decimator_if.sv
// Sample-in / average-out bundle for the boxcar decimator.
// Master drives samples and ready; slave returns results.
interface adc_boxcar_decimator_if #(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_N     = 4
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  overrun;
  logic [LOG2_N:0]       sample_ct;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  out_valid, out_data, overrun, sample_ct
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output out_valid, out_data, overrun, sample_ct
  );
endinterface

// File: rtl/adc_boxcar_decimator.sv
// Boxcar decimator: averages 2^LOG2_N signed ADC samples into
// one result held on a valid/ready register with sticky overrun.
module adc_boxcar_decimator #(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_N     = 4
) (
  input  logic                clk,
  input  logic                rst,
  adc_boxcar_decimator_if.slave bus
);
  localparam int AW = DATA_WIDTH + LOG2_N;
  localparam int CW = LOG2_N + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                  state_q;
  logic signed [AW-1:0]    acc_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    ovr_q;

  logic signed [DATA_WIDTH-1:0] smp;
  logic signed [AW-1:0]         sum_d;
  logic [DATA_WIDTH-1:0]        res_d;
  logic                         complete;

  // Gate the sample so idle-cycle garbage never reaches the adder.
  assign smp      = bus.in_valid ? bus.in_data : '0;
  assign sum_d    = acc_q + AW'(smp);
  assign res_d    = DATA_WIDTH'(sum_d >>> LOG2_N);
  assign complete = bus.in_valid && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else if (bus.clear) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (complete) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        data_q <= res_d;
      end else if (bus.in_valid) begin
        acc_q <= sum_d;
        cnt_q <= cnt_q + CW'(1);
      end
      unique case (state_q)
        EMPTY: begin
          if (complete) state_q <= FULL;
        end
        FULL: begin
          if (complete) begin
            if (!bus.out_ready) ovr_q <= 1'b1;
          end else if (bus.out_ready) begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.overrun   = ovr_q;
  assign bus.sample_ct = cnt_q;
endmodule

// File: tb/tb_adc_boxcar_decimator.sv
// Randomized and directed bench for the boxcar decimator,
// run at LOG2_N=2 and LOG2_N=0 against a sum/count model.
module tb_adc_boxcar_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_boxcar_decimator_if #(.DATA_WIDTH(24), .LOG2_N(2)) if2();
  adc_boxcar_decimator_if #(.DATA_WIDTH(24), .LOG2_N(0)) if0();

  adc_boxcar_decimator #(.DATA_WIDTH(24), .LOG2_N(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );
  adc_boxcar_decimator #(.DATA_WIDTH(24), .LOG2_N(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  int checks = 0;
  int errors = 0;

  // Model state: index 0 is the N=4 unit, index 1 the N=1 unit.
  longint      m_sum  [2];
  int          m_cnt  [2];
  bit          m_pend [2];
  logic [23:0] m_data [2];
  bit          m_ovr  [2];
  int          m_n    [2] = '{4, 1};
  int          vals   [4] = '{100, 200, 300, 400};

  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint fdiv(longint s, int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_sum[k]  = 0;
      m_cnt[k]  = 0;
      m_pend[k] = 0;
      m_data[k] = '0;
      m_ovr[k]  = 0;
    end
  endtask

  task automatic mstep(int k, bit v, logic [23:0] d, bit clr, bit rdy);
    bit     done;
    longint avg;
    done = 0;
    avg  = 0;
    if (clr) begin
      m_sum[k]  = 0;
      m_cnt[k]  = 0;
      m_pend[k] = 0;
      m_ovr[k]  = 0;
      return;
    end
    if (v) begin
      m_sum[k] += longint'($signed(d));
      m_cnt[k]++;
      if (m_cnt[k] == m_n[k]) begin
        avg      = fdiv(m_sum[k], m_n[k]);
        m_sum[k] = 0;
        m_cnt[k] = 0;
        done     = 1;
      end
    end
    if (done) begin
      if (m_pend[k] && !rdy) m_ovr[k] = 1;
      m_pend[k] = 1;
      m_data[k] = avg[23:0];
    end else if (m_pend[k] && rdy) begin
      m_pend[k] = 0;
    end
  endtask

  task automatic check_all();
    chk("v2",  if2.out_valid, m_pend[0]);
    chk("d2",  if2.out_data,  m_data[0]);
    chk("o2",  if2.overrun,   m_ovr[0]);
    chk("ct2", if2.sample_ct, m_cnt[0]);
    chk("v0",  if0.out_valid, m_pend[1]);
    chk("d0",  if0.out_data,  m_data[1]);
    chk("o0",  if0.overrun,   m_ovr[1]);
    chk("ct0", if0.sample_ct, m_cnt[1]);
  endtask

  task automatic step();
    mstep(0, if2.in_valid, if2.in_data, if2.clear, if2.out_ready);
    mstep(1, if0.in_valid, if0.in_data, if0.clear, if0.out_ready);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send2(logic [23:0] v);
    if2.in_valid = 1'b1;
    if2.in_data  = v;
    step();
    if2.in_valid = 1'b0;
  endtask

  task automatic blk4(logic [23:0] a, logic [23:0] b,
                      logic [23:0] c, logic [23:0] d);
    send2(a);
    send2(b);
    send2(c);
    send2(d);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_v", if2.out_valid, 0);
    chk("rst_d", if2.out_data,  0);
    chk("rst_c", if2.sample_ct, 0);
    chk("rst_o", if2.overrun,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mreset();
  endtask

  initial begin
    if2.in_valid = 0; if2.in_data = '0; if2.clear = 0; if2.out_ready = 1;
    if0.in_valid = 0; if0.in_data = '0; if0.clear = 0; if0.out_ready = 1;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_v", if2.out_valid, 0);
    chk("reset_d", if2.out_data,  0);
    chk("reset_c", if2.sample_ct, 0);
    rst = 1'b0;
    idle(2);

    // Spaced strobes, ready held high
    for (int i = 0; i < 4; i++) begin
      chk("t1_ct", if2.sample_ct, i);
      send2(24'(vals[i]));
      if (i == 3) begin
        chk("t1_v", if2.out_valid, 1);
        chk("t1_d", if2.out_data,  250);
        idle(1);
        chk("t1_v0", if2.out_valid, 0);
        idle(28);
      end else begin
        idle(29);
      end
    end
    chk("t1_ct0", if2.sample_ct, 0);

    // Rounding toward -inf and full-scale extremes
    blk4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE);
    chk("neg_d", if2.out_data, 24'hFFFFFE);
    blk4(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
    chk("max_d", if2.out_data, 24'h7FFFFF);
    blk4(24'h800000, 24'h800000, 24'h800000, 24'h800000);
    chk("min_d", if2.out_data, 24'h800000);
    idle(2);

    // Stalled consumer: overwrite sets sticky overrun
    if2.out_ready = 0;
    blk4(10, 10, 10, 10);
    chk("st_v",  if2.out_valid, 1);
    chk("st_d",  if2.out_data,  10);
    chk("st_o",  if2.overrun,   0);
    blk4(10, 10, 10, 10);
    chk("st_o1", if2.overrun,   1);
    blk4(20, 20, 20, 20);
    blk4(20, 20, 20, 20);
    chk("st_d2", if2.out_data,  20);
    chk("st_o2", if2.overrun,   1);
    if2.out_ready = 1;
    step();
    chk("st_vf", if2.out_valid, 0);
    idle(3);
    chk("st_os", if2.overrun,   1);
    if2.clear = 1;
    step();
    if2.clear = 0;
    chk("clr_o", if2.overrun,   0);
    chk("clr_d", if2.out_data,  20);

    // Drain and refill in the same cycle
    if2.out_ready = 0;
    blk4(7, 7, 7, 7);
    chk("bb_d1", if2.out_data, 7);
    send2(9);
    send2(9);
    send2(9);
    if2.out_ready = 1;
    send2(9);
    chk("bb_v", if2.out_valid, 1);
    chk("bb_d", if2.out_data,  9);
    chk("bb_o", if2.overrun,   0);
    step();
    chk("bb_v0", if2.out_valid, 0);

    // Partial block discarded by async reset, then by clear
    send2(500);
    send2(500);
    chk("pr_ct", if2.sample_ct, 2);
    async_reset();
    blk4(4, 8, 12, 16);
    chk("pr_d", if2.out_data, 10);
    idle(2);
    send2(500);
    send2(500);
    if2.clear    = 1;
    if2.in_valid = 1;
    if2.in_data  = 999;
    step();
    if2.clear    = 0;
    if2.in_valid = 0;
    chk("cl_ct", if2.sample_ct, 0);
    blk4(4, 8, 12, 16);
    chk("cl_d", if2.out_data, 10);
    idle(2);

    // Random streams on both units
    for (int i = 0; i < 1000; i++) begin
      if0.in_valid  = 1'($urandom_range(0, 1));
      if0.in_data   = 24'($urandom);
      if0.out_ready = 1'($urandom_range(0, 1));
      if2.in_valid  = 1'($urandom_range(0, 1));
      if2.in_data   = 24'($urandom);
      if2.out_ready = 1'($urandom_range(0, 1));
      if2.clear     = ($urandom_range(0, 49) == 0);
      if0.clear     = ($urandom_range(0, 199) == 0);
      step();
    end
    if2.in_valid = 0; if2.clear = 0;
    if0.in_valid = 0; if0.clear = 0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
